fixed_to_ascii: RTL and testbench

Streaming formatter that converts a 64-bit signed fixed-point result (value × 10^FRAC_DIGITS, two's complement) into an ASCII decimal character stream, e.g. 1500000 → "1.500000\r\n". It sits downstream of the calculator accumulator, between its result register and the UART transmitter / display text buffer. It is the output-direction counterpart of the operand entry path: it renders a number, where the entry path parses one. Conversion is iterative (double-dabble), and characters leave through a valid/ready handshake.

---
 rtl/fixed_fmt_pkg.sv | 37 +++
 rtl/fixed_to_ascii_bcd_dabble_step.sv | 27 ++
 rtl/fixed_to_ascii.sv | 133 +++++++++++++
 tb/tb_fixed_to_ascii.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fixed_fmt_pkg.sv
//------------------------------------------------------------------------------
// fixed_fmt_pkg : shared types and constants for the fixed-point ASCII formatter
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fixed_fmt_pkg;

  localparam int BCD_DIGITS = 20;
  localparam int BCD_W      = BCD_DIGITS * 4;
  localparam int CNT_W      = 7;
  localparam logic [CNT_W-1:0] LAST_ITER = 7'd63;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CONVERT = 4'd1,
    SIGN    = 4'd2,
    INT     = 4'd3,
    DOT     = 4'd4,
    FRAC    = 4'd5,
    CR      = 4'd6,
    LF      = 4'd7
  } state_t;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_0 + {4'b0000, d};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fixed_to_ascii_bcd_dabble_step.sv
//------------------------------------------------------------------------------
// bcd_dabble_step : one double-dabble iteration (adjust nibbles >= 5, shift in)
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_dabble_step
  import fixed_fmt_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  input  logic             shift_in,
  output logic [BCD_W-1:0] bcd_out
);

  logic [BCD_W-1:0] w_adj;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_nibble
    assign w_adj[4*i +: 4] = (bcd_in[4*i +: 4] >= 4'd5) ? (bcd_in[4*i +: 4] + 4'd3)
                                                        : bcd_in[4*i +: 4];
  end

  // The top nibble never overflows: 2^64-1 has 20 decimal digits.
  assign bcd_out = {w_adj[BCD_W-2:0], shift_in};

endmodule

`default_nettype wire

// File: rtl/fixed_to_ascii.sv
//------------------------------------------------------------------------------
// fixed_to_ascii : signed fixed-point (x10^FRAC_DIGITS) to ASCII decimal stream
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fixed_to_ascii
  import fixed_fmt_pkg::*;
#(
  parameter int FRAC_DIGITS = 6,
  parameter bit TERMINATE   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_char,
  output logic        busy
);

  localparam logic [4:0] C_FRAC_IDX = 5'(FRAC_DIGITS);

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_after_frac;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign;
  logic             r_nonzero;
  logic [63:0]      r_mag;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_bcd_step;
  logic [4:0]       r_idx;
  logic [4:0]       w_first_int;
  logic             w_hs;
  logic             w_last_iter;

  bcd_dabble_step u_step (
    .bcd_in  (r_bcd),
    .shift_in(r_mag[63]),
    .bcd_out (w_bcd_step)
  );

  assign w_hs         = out_valid && out_ready;
  assign w_last_iter  = (r_cnt == LAST_ITER);
  assign w_after_frac = TERMINATE ? CR : IDLE;

  // Encoder runs on the final shift result so the start digit is latched
  // on the same edge that leaves CONVERT.
  always_comb begin
    w_first_int = C_FRAC_IDX;
    for (int i = FRAC_DIGITS; i < BCD_DIGITS; i++) begin
      if (w_bcd_step[4*i +: 4] != 4'd0) w_first_int = 5'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_nonzero <= 1'b0;
      r_mag     <= '0;
      r_bcd     <= '0;
      r_idx     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign    <= in_data[63];
            r_nonzero <= |in_data;
            r_mag     <= in_data[63] ? (~in_data + 64'd1) : in_data;
            r_bcd     <= '0;
            r_cnt     <= '0;
          end
        end
        CONVERT: begin
          r_bcd <= w_bcd_step;
          r_mag <= {r_mag[62:0], 1'b0};
          r_cnt <= r_cnt + 7'd1;
          if (w_last_iter) r_idx <= w_first_int;
        end
        INT: begin
          if (w_hs && (r_idx != C_FRAC_IDX)) r_idx <= r_idx - 5'd1;
        end
        DOT: begin
          if (w_hs) r_idx <= C_FRAC_IDX - 5'd1;
        end
        FRAC: begin
          if (w_hs && (r_idx != 5'd0)) r_idx <= r_idx - 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = CONVERT;
      CONVERT: if (w_last_iter) w_state_next = (r_sign && r_nonzero) ? SIGN : INT;
      SIGN:    if (w_hs) w_state_next = INT;
      INT:     if (w_hs && (r_idx == C_FRAC_IDX)) w_state_next = DOT;
      DOT:     if (w_hs) w_state_next = (FRAC_DIGITS == 0) ? w_after_frac : FRAC;
      FRAC:    if (w_hs && (r_idx == 5'd0)) w_state_next = w_after_frac;
      CR:      if (w_hs) w_state_next = LF;
      LF:      if (w_hs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state != IDLE);
    out_valid = 1'b0;
    out_char  = 8'h00;
    case (r_state)
      SIGN: begin out_valid = 1'b1; out_char = ASCII_MINUS; end
      INT,
      FRAC: begin out_valid = 1'b1; out_char = digit_char(r_bcd[{r_idx, 2'b00} +: 4]); end
      DOT:  begin out_valid = 1'b1; out_char = ASCII_DOT; end
      CR:   begin out_valid = 1'b1; out_char = ASCII_CR; end
      LF:   begin out_valid = 1'b1; out_char = ASCII_LF; end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_to_ascii.sv
//------------------------------------------------------------------------------
// tb_fixed_to_ascii : directed self-checking bench for fixed_to_ascii
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fixed_to_ascii;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;   // 0: CR/LF instance, 1: unterminated instance

  logic        ir1, ov1, bz1, ir0, ov0, bz0;
  logic [7:0]  oc1, oc0;
  logic        iv1, iv0, or1, or0;
  logic        cur_ready_in, cur_valid, cur_busy;
  logic [7:0]  cur_char;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign iv1 = in_valid & ~sel;
  assign iv0 = in_valid & sel;
  assign or1 = out_ready & ~sel;
  assign or0 = out_ready & sel;
  assign cur_ready_in = sel ? ir0 : ir1;
  assign cur_valid    = sel ? ov0 : ov1;
  assign cur_busy     = sel ? bz0 : bz1;
  assign cur_char     = sel ? oc0 : oc1;

  fixed_to_ascii #(.FRAC_DIGITS(6), .TERMINATE(1'b1)) dut_t (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(or1), .out_char(oc1), .busy(bz1)
  );

  fixed_to_ascii #(.FRAC_DIGITS(6), .TERMINATE(1'b0)) dut_n (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(or0), .out_char(oc0), .busy(bz0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic s, input logic [63:0] v);
    sel = s;
    @(negedge clk);
    check("accept_ready", 64'(cur_ready_in), 64'd1);
    in_data  = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts active edges after the accept edge until out_valid is seen.
  task automatic wait_first(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (cur_valid) break;
      @(posedge clk);
      n++;
    end
  endtask

  // Entered at a negedge; leaves at the negedge after the last handshake.
  task automatic collect(input string exp, input int duty, input logic pulse);
    int   got = 0;
    int   cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;
    check("busy_stream", 64'(cur_busy), 64'd1);
    while (got < exp.len() && cyc < 400) begin
      if (stalled) begin
        check("stall_valid", 64'(cur_valid), 64'd1);
        check("stall_hold", 64'(cur_char), 64'(held));
      end
      if (duty >= 100) check("no_bubble", 64'(cur_valid), 64'd1);
      out_ready = ($urandom_range(99) < duty);
      if (pulse) begin
        in_data  = 64'd99000000;
        in_valid = (cyc % 3 == 1);
      end
      if (cur_valid && out_ready) begin
        check("char", 64'(cur_char), 64'(exp[got]));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = cur_valid;
        held    = cur_char;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream_len", 64'(got), 64'(exp.len()));
    check("idle_ready", 64'(cur_ready_in), 64'd1);
    check("idle_busy", 64'(cur_busy), 64'd0);
    check("idle_valid", 64'(cur_valid), 64'd0);
  endtask

  task automatic run(input logic s, input logic [63:0] v, input string exp,
                     input int duty, input logic pulse);
    int n;
    start(s, v);
    wait_first(n);
    check("first_latency", 64'(n), 64'd64);
    collect(exp, duty, pulse);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ir1), 64'd1);
    check("rst_valid", 64'(ov1), 64'd0);
    check("rst_char", 64'(oc1), 64'd0);
    check("rst_busy", 64'(bz1), 64'd0);
    check("rst_valid_n", 64'(ov0), 64'd0);
    reset = 1'b0;

    run(1'b0, 64'd1500000, "1.500000\015\012", 100, 1'b0);
    run(1'b0, 64'd0, "0.000000\015\012", 100, 1'b0);
    run(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "-0.000001\015\012", 100, 1'b0);
    run(1'b0, 64'h8000_0000_0000_0000, "-9223372036854.775808\015\012", 100, 1'b0);
    run(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, "9223372036854.775807\015\012", 100, 1'b0);
    run(1'b0, 64'd42000000, "42.000000\015\012", 30, 1'b1);

    // The in_valid pulses during busy must not have queued a second line.
    repeat (70) @(posedge clk);
    @(negedge clk);
    check("no_queued", 64'(ov1), 64'd0);

    run(1'b1, -64'sd2500000, "-2.500000", 100, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("noterm_idle", 64'(ov0), 64'd0);

    // Abort mid-stream after the third character.
    start(1'b0, 64'd1500000);
    wait_first(n);
    repeat (3) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_abort_char", 64'(oc1), 64'h30);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    check("abort_s_valid", 64'(ov1), 64'd0);
    check("abort_s_ready", 64'(ir1), 64'd1);

    // Abort mid-CONVERT.
    start(1'b0, 64'd1500000);
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_c_valid", 64'(ov1), 64'd0);
    check("abort_c_ready", 64'(ir1), 64'd1);

    run(1'b0, 64'd7000000, "7.000000\015\012", 100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
